// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: stretches single-cycle event strobes into visible
// LED flashes with a minimum on-time and off-gap, queueing extra strobes.
module led_pulse_stretcher #(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int PRESCALE  = 16,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_in,
    input  logic              ovf_clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int ON_CYC  = ON_TICKS * PRESCALE;
    localparam int OFF_CYC = OFF_TICKS * PRESCALE;
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;
    logic              drop;

    // State, timer, queue depth and the registered LED/busy decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
            led     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pend_nxt;
            ovf     <= ovf_nxt;
            led     <= (state_nxt == ON);
            busy    <= (state_nxt != IDLE);
        end
    end

    // Flash sequencing; a strobe arriving while a queued flash launches
    // replaces it in the queue, so depth stays put and nothing is dropped.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pend_nxt  = pending;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (event_in) begin
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                end else if (pending != '0) begin
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                    pend_nxt  = pending - 1'b1;
                end
            end
            ON: begin
                timer_nxt = timer - 1'b1;
                if (timer == '0) begin
                    state_nxt = OFF;
                    timer_nxt = OFF_LOAD;
                end
                if (event_in) begin
                    if (pending == PEND_MAX) begin
                        drop = 1'b1;
                    end else begin
                        pend_nxt = pending + 1'b1;
                    end
                end
            end
            OFF: begin
                timer_nxt = timer - 1'b1;
                if (timer == '0) begin
                    if (pending != '0) begin
                        state_nxt = ON;
                        timer_nxt = ON_LOAD;
                        if (!event_in) begin
                            pend_nxt = pending - 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                        if (event_in) begin
                            pend_nxt = pending + 1'b1;
                        end
                    end
                end else if (event_in) begin
                    if (pending == PEND_MAX) begin
                        drop = 1'b1;
                    end else begin
                        pend_nxt = pending + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
        ovf_nxt = drop | (ovf & ~ovf_clr);
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed scenarios plus a randomized run checked
// against a schedule-of-flashes reference model.
module tb_led_pulse_stretcher;

    localparam int ON_T   = 4;
    localparam int OFF_T  = 4;
    localparam int PS     = 16;
    localparam int PW     = 3;
    localparam int ON_CYC = ON_T * PS;
    localparam int PERIOD = (ON_T + OFF_T) * PS;
    localparam int PMAX   = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          event_in = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;

    int n_cmp = 0;
    int n_bad = 0;

    led_pulse_stretcher #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .PRESCALE (PS),
        .PEND_W   (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .event_in(event_in),
        .ovf_clr (ovf_clr),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted strobe becomes a scheduled flash
    // (strobe cycle, start cycle); outputs are derived from the schedule.
    typedef struct {
        int ev;
        int st;
    } fl_t;

    fl_t fl[$];
    int  cyc;
    int  next_free;
    bit  m_ovf;

    function automatic bit m_led();
        foreach (fl[i])
            if (cyc >= fl[i].st && cyc < fl[i].st + ON_CYC) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        foreach (fl[i])
            if (cyc >= fl[i].st && cyc < fl[i].st + PERIOD) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend();
        int n = 0;
        foreach (fl[i])
            if (fl[i].st > cyc && fl[i].ev < cyc) n++;
        return n;
    endfunction

    task automatic model_reset();
        fl.delete();
        next_free = -1000;
        m_ovf = 1'b0;
        cyc = 0;
    endtask

    // Drive one cycle of inputs, advance the model, end at next negedge.
    task automatic tick(input bit ev, input bit clr);
        int  s;
        int  np;
        bit  drop;
        fl_t f;
        event_in = ev;
        ovf_clr = clr;
        drop = 1'b0;
        if (ev) begin
            if (cyc + 1 < next_free) s = next_free;
            else if (cyc + 1 == next_free) s = cyc + 2;
            else s = cyc + 1;
            np = 0;
            foreach (fl[i]) if (fl[i].st > cyc + 1) np++;
            if (s > cyc + 1) np++;
            if (np > PMAX) begin
                drop = 1'b1;
            end else begin
                f.ev = cyc;
                f.st = s;
                fl.push_back(f);
                next_free = s + PERIOD;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        cyc++;
        while (fl.size() > 0 && fl[0].st + PERIOD + 2 < cyc) void'(fl.pop_front());
        @(negedge clk);
        event_in = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        event_in = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({led, busy, ovf, pending} !== '0) begin
            n_bad++;
            $display("FAIL reset: got led=%b busy=%b ovf=%b pend=%0d want all 0",
                     led, busy, ovf, pending);
        end
    endtask

    task automatic test_single();
        bit el;
        bit eb;
        do_reset();
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 140; k++) begin
            el = (k <= 64);
            eb = (k <= 128);
            n_cmp++;
            if (led !== el || busy !== eb || pending !== '0) begin
                n_bad++;
                $display("FAIL single k=%0d: got led=%b busy=%b pend=%0d want %b %b 0",
                         k, led, busy, pending, el, eb);
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_three();
        bit el;
        int ep;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int k = 3; k <= 400; k++) begin
            el = (k < 1 + 3 * PERIOD) && (((k - 1) % PERIOD) < ON_CYC);
            ep = (k < 129) ? 2 : (k < 257) ? 1 : 0;
            n_cmp++;
            if (led !== el || int'(pending) !== ep || ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL three k=%0d: got led=%b pend=%0d ovf=%b want %b %0d 0",
                         k, led, pending, ovf, el, ep);
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_saturate();
        int  rises;
        bit  prev;
        do_reset();
        tick(1'b1, 1'b0);
        prev = 1'b0;
        rises = 0;
        for (int k = 1; k <= 9 * PERIOD; k++) begin
            if (led && !prev) rises++;
            prev = led;
            tick((k % 2 == 0) && k <= 20, 1'b0);
            if (k == 22) begin
                n_cmp++;
                if (pending !== 3'd7 || ovf !== 1'b1) begin
                    n_bad++;
                    $display("FAIL saturate: got pend=%0d ovf=%b want 7 1", pending, ovf);
                end
            end
        end
        n_cmp++;
        if (rises != 8 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_flashes: got %0d flashes busy=%b want 8 0", rises, busy);
        end
    endtask

    task automatic test_sat_simul();
        int rises;
        bit prev;
        do_reset();
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
        while (cyc < 128) tick(1'b0, 1'b0);
        n_cmp++;
        if (pending !== 3'd7 || led !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_pre: got pend=%0d led=%b want 7 0", pending, led);
        end
        tick(1'b1, 1'b0);
        n_cmp++;
        if (pending !== 3'd7 || ovf !== 1'b0 || led !== 1'b1) begin
            n_bad++;
            $display("FAIL simul: got pend=%0d ovf=%b led=%b want 7 0 1",
                     pending, ovf, led);
        end
        prev = 1'b0;
        rises = 0;
        for (int k = 0; k < 9 * PERIOD && busy; k++) begin
            if (led && !prev) rises++;
            prev = led;
            tick(1'b0, 1'b0);
        end
        n_cmp++;
        if (rises != 8 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_drain: got %0d flashes busy=%b want 8 0", rises, busy);
        end
    endtask

    task automatic test_ovf_clr();
        do_reset();
        for (int k = 0; k < 9; k++) tick(1'b1, 1'b0);
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: got %b want 1", ovf);
        end
        tick(1'b0, 1'b1);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clr: got %b want 0", ovf);
        end
        tick(1'b1, 1'b1);
        n_cmp++;
        if (ovf !== 1'b1 || pending !== 3'd7) begin
            n_bad++;
            $display("FAIL ovf_clr_drop: got ovf=%b pend=%0d want 1 7", ovf, pending);
        end
    endtask

    task automatic test_midflash_reset();
        bit el;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        while (cyc < 30) tick(1'b0, 1'b0);
        n_cmp++;
        if (pending !== 3'd2 || led !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got pend=%0d led=%b want 2 1", pending, led);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({led, busy, ovf, pending} !== '0) begin
            n_bad++;
            $display("FAIL mid_rst: got led=%b busy=%b ovf=%b pend=%0d want all 0",
                     led, busy, ovf, pending);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            el = (k <= ON_CYC);
            n_cmp++;
            if (led !== el || pending !== '0 || busy !== (k <= PERIOD)) begin
                n_bad++;
                $display("FAIL mid_after k=%0d: got led=%b pend=%0d busy=%b want %b 0 %b",
                         k, led, pending, busy, el, (k <= PERIOD));
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        int  thr;
        bit  ev;
        bit  clr;
        do_reset();
        thr = 5;
        for (int k = 0; k < 8000; k++) begin
            if (k % 400 == 0) thr = $urandom_range(0, 3) * 12 + 1;
            n_cmp++;
            if (led !== m_led() || busy !== m_busy() ||
                int'(pending) !== m_pend() || ovf !== m_ovf) begin
                n_bad++;
                $display("FAIL random c=%0d: got led=%b busy=%b pend=%0d ovf=%b want %b %b %0d %b",
                         cyc, led, busy, pending, ovf, m_led(), m_busy(), m_pend(), m_ovf);
            end
            ev = ($urandom_range(0, 99) < thr);
            clr = ($urandom_range(0, 63) == 0);
            tick(ev, clr);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_three();
        test_saturate();
        test_sat_simul();
        test_ovf_clr();
        test_midflash_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
